// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated two-way intersection phase scheduler with min/gap/max green limits.
// Define TRAFFIC_PED_PHASE_EN to compile in the pedestrian WALK phase.
module traffic_phase_scheduler #(
   parameter int unsigned MIN_GREEN     = 10,
   parameter int unsigned MAX_GREEN     = 30,
   parameter int unsigned GAP_CYCLES    = 4,
   parameter int unsigned YELLOW_CYCLES = 5,
   parameter int unsigned ALLRED_CYCLES = 3,
   parameter int unsigned WALK_CYCLES   = 8,
   parameter int unsigned CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ns_sense,
   input  logic       ew_sense,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic [2:0] phase
);

   if (MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN || GAP_CYCLES < 1 || YELLOW_CYCLES < 1 ||
       ALLRED_CYCLES < 1 || WALK_CYCLES < 1) begin : g_bad_timing
      $error("traffic_phase_scheduler: illegal timing parameters");
   end
   if (CNT_W < 1 || CNT_W > 31 || MAX_GREEN >= (32'd1 << CNT_W)) begin : g_bad_width
      $error("traffic_phase_scheduler: CNT_W cannot hold MAX_GREEN");
   end

   localparam logic [CNT_W-1:0] MinLast    = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MaxLast    = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] GapFull    = CNT_W'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] AllredLast = CNT_W'(ALLRED_CYCLES - 1);

   typedef enum logic [2:0] {
      StAllred   = 3'd0,
      StNsGreen  = 3'd1,
      StNsYellow = 3'd2,
      StEwGreen  = 3'd3,
`ifdef TRAFFIC_PED_PHASE_EN
      StEwYellow = 3'd4,
      StWalk     = 3'd5
`else
      StEwYellow = 3'd4
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic             next_dir_q, next_dir_d;
   logic             ns_call_q, ns_call_d;
   logic             ew_call_q, ew_call_d;
   logic             ped_call;
   logic             walk_go;
   logic             in_green, own_sense, opp_call, green_done, entering;

   always_comb begin
      in_green   = (state_q == StNsGreen) || (state_q == StEwGreen);
      own_sense  = (state_q == StNsGreen) ? ns_sense : ew_sense;
      opp_call   = (state_q == StNsGreen) ? ew_call_q : ns_call_q;
      // Only opposing or pedestrian demand may end a green; otherwise it rests.
      green_done = (tmr_q >= MinLast) && (opp_call || ped_call) &&
                   ((gap_q == GapFull) || (tmr_q == MaxLast));

      state_d = state_q;
      case (state_q)
         StAllred: begin
            if (tmr_q == AllredLast) begin
`ifdef TRAFFIC_PED_PHASE_EN
               if (walk_go) state_d = StWalk;
               else         state_d = next_dir_q ? StEwGreen : StNsGreen;
`else
               state_d = next_dir_q ? StEwGreen : StNsGreen;
`endif
            end
         end
         StNsGreen:  if (green_done) state_d = StNsYellow;
         StNsYellow: if (tmr_q == YellowLast) state_d = StAllred;
         StEwGreen:  if (green_done) state_d = StEwYellow;
         StEwYellow: if (tmr_q == YellowLast) state_d = StAllred;
`ifdef TRAFFIC_PED_PHASE_EN
         // Both directions are already red, so WALK hands straight over to a green.
         StWalk: begin
            if (tmr_q == CNT_W'(WALK_CYCLES - 1)) begin
               state_d = next_dir_q ? StEwGreen : StNsGreen;
            end
         end
`endif
         default: state_d = StAllred;
      endcase
   end

   always_comb begin
      entering = (state_d != state_q);

      tmr_d = tmr_q + 1'b1;
      if (entering) tmr_d = '0;
      else if (in_green && (tmr_q == MaxLast)) tmr_d = tmr_q;

      gap_d = '0;
      if (in_green && !entering && !own_sense) begin
         gap_d = (gap_q == GapFull) ? gap_q : gap_q + 1'b1;
      end

      next_dir_d = next_dir_q;
      if (entering && (state_d == StNsGreen)) next_dir_d = 1'b1;
      if (entering && (state_d == StEwGreen)) next_dir_d = 1'b0;

      // A set in the same cycle as the clear wins.
      ns_call_d = ns_call_q;
      if (ns_sense && (state_q != StNsGreen))      ns_call_d = 1'b1;
      else if (entering && (state_d == StNsGreen)) ns_call_d = 1'b0;

      ew_call_d = ew_call_q;
      if (ew_sense && (state_q != StEwGreen))      ew_call_d = 1'b1;
      else if (entering && (state_d == StEwGreen)) ew_call_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StAllred;
         tmr_q      <= '0;
         gap_q      <= '0;
         next_dir_q <= 1'b0;
         ns_call_q  <= 1'b0;
         ew_call_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         gap_q      <= gap_d;
         next_dir_q <= next_dir_d;
         ns_call_q  <= ns_call_d;
         ew_call_q  <= ew_call_d;
      end
   end

`ifdef TRAFFIC_PED_PHASE_EN
   logic ped_call_q, ped_call_d;
   logic prev_yellow_q, prev_yellow_d;

   always_comb begin
      ped_call_d = ped_call_q;
      if (ped_req)                              ped_call_d = 1'b1;
      else if (entering && (state_d == StWalk)) ped_call_d = 1'b0;

      // WALK is only granted from an all-red that followed a yellow, never out of reset.
      prev_yellow_d = prev_yellow_q;
      if (entering) prev_yellow_d = (state_q == StNsYellow) || (state_q == StEwYellow);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ped_call_q    <= 1'b0;
         prev_yellow_q <= 1'b0;
      end else begin
         ped_call_q    <= ped_call_d;
         prev_yellow_q <= prev_yellow_d;
      end
   end

   assign ped_call = ped_call_q;
   assign walk_go  = ped_call_q && prev_yellow_q;
`else
   logic unused_ped_req;
   assign unused_ped_req = ped_req;
   assign ped_call       = 1'b0;
   assign walk_go        = 1'b0;
`endif

   always_comb begin
      ns_light = 3'b100;
      ew_light = 3'b100;
      walk     = 1'b0;
      case (state_q)
         StNsGreen:  ns_light = 3'b001;
         StNsYellow: ns_light = 3'b010;
         StEwGreen:  ew_light = 3'b001;
         StEwYellow: ew_light = 3'b010;
`ifdef TRAFFIC_PED_PHASE_EN
         StWalk:     walk     = 1'b1;
`endif
         default: ;
      endcase
   end

   assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed and randomized bench for traffic_phase_scheduler against a phase-level reference model.
// Honours TRAFFIC_PED_PHASE_EN the same way as the design.
module tb_traffic_phase_scheduler;

   localparam int MinG = 4;
   localparam int MaxG = 8;
   localparam int Gap  = 2;
   localparam int Yel  = 2;
   localparam int Ar   = 2;
   localparam int Wk   = 3;
`ifdef TRAFFIC_PED_PHASE_EN
   localparam bit PedEn = 1'b1;
`else
   localparam bit PedEn = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       ns_sense;
   logic       ew_sense;
   logic       ped_req;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       walk;
   logic [2:0] phase;

   int n_cmp;
   int n_fail;

   // Reference model: phase code, cycles shown so far in this phase, quiet-cycle run.
   int m_ph;
   int m_len;
   int m_quiet;
   bit m_nc, m_ec, m_pc, m_next, m_after_yellow;

   traffic_phase_scheduler #(
      .MIN_GREEN    (MinG),
      .MAX_GREEN    (MaxG),
      .GAP_CYCLES   (Gap),
      .YELLOW_CYCLES(Yel),
      .ALLRED_CYCLES(Ar),
      .WALK_CYCLES  (Wk),
      .CNT_W        (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ns_sense(ns_sense),
      .ew_sense(ew_sense),
      .ped_req (ped_req),
      .ns_light(ns_light),
      .ew_light(ew_light),
      .walk    (walk),
      .phase   (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] lamps(input int ph);
      case (ph)
         1:       return 7'b001_100_0;
         2:       return 7'b010_100_0;
         3:       return 7'b100_001_0;
         4:       return 7'b100_010_0;
         5:       return 7'b100_100_1;
         default: return 7'b100_100_0;
      endcase
   endfunction

   function automatic void model_step(input bit r, input bit ns, input bit ew, input bit pd);
      int nph;
      bit green;
      bit own;
      bit opp;
      if (r) begin
         m_ph = 0; m_len = 1; m_quiet = 0;
         m_nc = 0; m_ec = 0; m_pc = 0; m_next = 0; m_after_yellow = 0;
         return;
      end
      green = (m_ph == 1) || (m_ph == 3);
      own   = (m_ph == 1) ? ns : ew;
      opp   = (m_ph == 1) ? m_ec : m_nc;
      nph   = m_ph;
      case (m_ph)
         0:       if (m_len >= Ar) nph = (m_pc && m_after_yellow) ? 5 : (m_next ? 3 : 1);
         2, 4:    if (m_len >= Yel) nph = 0;
         5:       if (m_len >= Wk) nph = m_next ? 3 : 1;
         default: if (m_len >= MinG && (opp || m_pc) && (m_quiet >= Gap || m_len >= MaxG))
                     nph = m_ph + 1;
      endcase
      if (ns && m_ph != 1) m_nc = 1; else if (nph == 1 && m_ph != 1) m_nc = 0;
      if (ew && m_ph != 3) m_ec = 1; else if (nph == 3 && m_ph != 3) m_ec = 0;
      if (PedEn && pd) m_pc = 1; else if (nph == 5 && m_ph != 5) m_pc = 0;
      if (nph != m_ph) begin
         m_after_yellow = (m_ph == 2) || (m_ph == 4);
         if (nph == 1) m_next = 1;
         if (nph == 3) m_next = 0;
         m_ph = nph; m_len = 1; m_quiet = 0;
      end else begin
         if (green) m_quiet = own ? 0 : ((m_quiet < Gap) ? m_quiet + 1 : Gap);
         if (!(green && m_len >= MaxG)) m_len++;
      end
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit r, input bit ns, input bit ew, input bit pd);
      logic [6:0] e;
      rst = r; ns_sense = ns; ew_sense = ew; ped_req = pd;
      @(posedge clk);
      model_step(r, ns, ew, pd);
      #1;
      e = lamps(m_ph);
      check("model_phase", 8'(phase), 8'(m_ph));
      check("model_ns", 8'(ns_light), 8'(e[6:4]));
      check("model_ew", 8'(ew_light), 8'(e[3:1]));
      check("model_walk", 8'(walk), 8'(e[0]));
   endtask

   // Three reset cycles, then two released edges: expects phase 0,0,1 with NS green last.
   task automatic reset_and_start(input bit ns);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, ns, 1'b0, 1'b0);
         check("rst_ns", 8'(ns_light), 8'h4);
         check("rst_ew", 8'(ew_light), 8'h4);
         check("rst_walk", 8'(walk), 8'h0);
         check("rst_phase", 8'(phase), 8'h0);
      end
      tick(1'b0, ns, 1'b0, 1'b0);
      check("rel1_phase", 8'(phase), 8'h0);
      tick(1'b0, ns, 1'b0, 1'b0);
      check("rel2_phase", 8'(phase), 8'h1);
      check("rel2_ns", 8'(ns_light), 8'h1);
   endtask

   initial begin
      int glen;
      int ped_exp [11];
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; ns_sense = 1'b0; ew_sense = 1'b0; ped_req = 1'b0;
`ifdef TRAFFIC_PED_PHASE_EN
      ped_exp = '{1, 1, 1, 2, 2, 0, 0, 5, 5, 5, 3};
`else
      ped_exp = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

      // Rest in NS green with no demand.
      reset_and_start(1'b0);
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         check("rest_ns", 8'(ns_light), 8'h1);
         check("rest_ew", 8'(ew_light), 8'h4);
      end

      // Gap-out after minimum green.
      reset_and_start(1'b0);
      glen = 1;
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20 && phase == 3'd1; i++) begin
         glen++;
         tick(1'b0, 1'b0, 1'b0, 1'b0);
      end
      check("gapout_len", 8'(glen), 8'd4);
      check("gapout_y1", 8'(ns_light), 8'h2);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("gapout_y2", 8'(ns_light), 8'h2);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("gapout_ar1", 8'({ns_light, ew_light}), 8'h24);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("gapout_ar2", 8'({ns_light, ew_light}), 8'h24);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("gapout_ew", 8'(ew_light), 8'h1);

      // Max-out with continuous NS demand.
      reset_and_start(1'b1);
      glen = 1;
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 20 && phase == 3'd1; i++) begin
         glen++;
         tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
      check("maxout_len", 8'(glen), 8'd8);
      check("maxout_yellow", 8'(phase), 8'h2);

      // Pedestrian request during a resting NS green.
      reset_and_start(1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 11; k++) begin
         check("ped_phase", 8'(phase), 8'(ped_exp[k]));
         check("ped_walk", 8'(walk), (ped_exp[k] == 5) ? 8'h1 : 8'h0);
         tick(1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Reset in EW yellow goes straight to all-red, then NS is served first.
      reset_and_start(1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 30 && phase != 3'd3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 30 && phase != 3'd4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("midrst_reach_ew_y", 8'(phase), 8'h4);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("midrst_phase", 8'(phase), 8'h0);
      check("midrst_lamps", 8'({ns_light, ew_light}), 8'h24);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("midrst_ns_first", 8'(phase), 8'h1);

      // Randomized demand in blocks of varying density, with rare resets.
      for (int blk = 0; blk < 12; blk++) begin
         int dn;
         int de;
         dn = int'($urandom_range(0, 4));
         de = int'($urandom_range(0, 4));
         for (int i = 0; i < 50; i++) begin
            tick($urandom_range(0, 149) == 0,
                 int'($urandom_range(1, 4)) <= dn,
                 int'($urandom_range(1, 4)) <= de,
                 $urandom_range(0, 39) == 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
